// File: rtl/exe_stage_pipelined.sv
// Execute stage: operand forwarding, Val2 generation, ALU/flags, branch target, registered EXE/MEM.
// Define EXE_MUL_EN to build the iterative multicycle MUL and its stall FSM.
module exe_stage_pipelined #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned BR_SHIFT   = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              freeze,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] val_Rn,
    input  logic [DATA_W-1:0] val_Rm,
    input  logic [DATA_W-1:0] val_MEM_stage,
    input  logic [DATA_W-1:0] val_WB_stage,
    input  logic [1:0]        src1_sel,
    input  logic [1:0]        src2_sel,
    input  logic [3:0]        EX_command,
    input  logic [3:0]        SR,
    input  logic [3:0]        dst,
    input  logic              mem_R,
    input  logic              mem_W,
    input  logic              imm,
    input  logic              WB_en,
    input  logic              B,
    input  logic [11:0]       shifter_operand,
    input  logic [23:0]       signed_immediate,
    output logic              stall,
    output logic              out_valid,
    output logic [DATA_W-1:0] ALU_res,
    output logic [DATA_W-1:0] val_Rm_out,
    output logic [DATA_W-1:0] branch_addr,
    output logic [3:0]        SR_out,
    output logic [3:0]        dst_out,
    output logic              mem_R_out,
    output logic              mem_W_out,
    output logic              WB_en_out,
    output logic              B_out
);
    localparam int unsigned MSB = DATA_W - 1;
    localparam logic [3:0] OP_MOV = 4'b0001, OP_MVN = 4'b1001, OP_ADD = 4'b0010;
    localparam logic [3:0] OP_ADC = 4'b0011, OP_SUB = 4'b0100, OP_SBC = 4'b0101;
    localparam logic [3:0] OP_AND = 4'b0110, OP_ORR = 4'b0111, OP_EOR = 4'b1000;
    localparam logic [3:0] OP_MUL = 4'b1010;

    function automatic logic [DATA_W-1:0] ror(input logic [DATA_W-1:0] x, input int unsigned n);
        int unsigned m;
        m = n % DATA_W;
        return (x >> m) | (x << (DATA_W - m));
    endfunction

    function automatic logic [DATA_W-1:0] fwd(input logic [1:0] sel, input logic [DATA_W-1:0] v);
        case (sel)
            2'b01:   return val_MEM_stage;
            2'b10:   return val_WB_stage;
            default: return v;
        endcase
    endfunction

    logic [DATA_W-1:0] w_op_a, w_op_r, w_val2, w_alu_res, w_br_off;
    logic [DATA_W:0]   w_sum;
    logic              w_c, w_v, w_idle, w_is_mul, w_wr;
    int unsigned       w_sh_amt;
    logic [DATA_W-1:0] w_wr_res, w_wr_rm, w_wr_br;
    logic [3:0]        w_wr_sr, w_wr_dst, w_wr_ctrl;

    logic              r_out_valid, r_mem_r, r_mem_w, r_wb_en, r_b;
    logic [DATA_W-1:0] r_alu_res, r_val_rm, r_branch;
    logic [3:0]        r_sr, r_dst;

    assign w_op_a   = fwd(src1_sel, val_Rn);
    assign w_op_r   = fwd(src2_sel, val_Rm);
    assign w_br_off = DATA_W'($signed(signed_immediate)) << BR_SHIFT;

    always_comb begin
        w_sh_amt = 32'(shifter_operand[11:7]) % DATA_W;
        if (mem_R | mem_W) begin
            w_val2 = DATA_W'(shifter_operand);
        end else if (imm) begin
            w_val2 = ror(DATA_W'(shifter_operand[7:0]), {27'd0, shifter_operand[11:8], 1'b0});
        end else begin
            case (shifter_operand[6:5])
                2'b00:   w_val2 = w_op_r << w_sh_amt;
                2'b01:   w_val2 = w_op_r >> w_sh_amt;
                2'b10:   w_val2 = $signed(w_op_r) >>> w_sh_amt;
                default: w_val2 = ror(w_op_r, w_sh_amt);
            endcase
        end
    end

    always_comb begin
        w_sum     = '0;
        w_alu_res = '0;
        w_c       = SR[1];
        w_v       = SR[0];
        case (EX_command)
            OP_MOV, OP_MUL: w_alu_res = w_val2;
            OP_MVN:         w_alu_res = ~w_val2;
            OP_AND:         w_alu_res = w_op_a & w_val2;
            OP_ORR:         w_alu_res = w_op_a | w_val2;
            OP_EOR:         w_alu_res = w_op_a ^ w_val2;
            OP_ADD, OP_ADC: begin
                w_sum = {1'b0, w_op_a} + {1'b0, w_val2}
                      + {{DATA_W{1'b0}}, (EX_command == OP_ADC) & SR[1]};
                w_alu_res = w_sum[MSB:0];
                w_c       = w_sum[DATA_W];
                w_v       = (w_op_a[MSB] == w_val2[MSB]) & (w_alu_res[MSB] != w_op_a[MSB]);
            end
            OP_SUB, OP_SBC: begin
                // a + ~b + cin: carry out is the not-borrow flag
                w_sum = {1'b0, w_op_a} + {1'b0, ~w_val2}
                      + {{DATA_W{1'b0}}, (EX_command == OP_SUB) | SR[1]};
                w_alu_res = w_sum[MSB:0];
                w_c       = w_sum[DATA_W];
                w_v       = (w_op_a[MSB] != w_val2[MSB]) & (w_alu_res[MSB] != w_op_a[MSB]);
            end
            default: w_alu_res = '0;
        endcase
    end

`ifdef EXE_MUL_EN
    localparam int unsigned K     = DATA_W / MUL_CYCLES;
    localparam int unsigned CNT_W = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

    typedef enum logic {StIdle, StMul} mul_state_e;
    mul_state_e        r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [DATA_W-1:0] r_mul_a, r_mul_b, r_acc;
    logic [1:0]        r_mul_cv;
    logic [3:0]        r_mul_dst;
    logic              r_mul_wb;
    logic [DATA_W-1:0] w_b_sh, w_partial, w_acc_next;
    logic [K-1:0]      w_chunk;
    logic              w_mul_last;

    assign w_idle     = (r_state == StIdle);
    assign w_is_mul   = (EX_command == OP_MUL);
    assign w_mul_last = (r_cnt == CNT_W'(MUL_CYCLES - 1));
    assign w_b_sh     = r_mul_b >> (K * r_cnt);
    assign w_chunk    = w_b_sh[K-1:0];
    assign w_partial  = (r_mul_a * DATA_W'(w_chunk)) << (K * r_cnt);
    assign w_acc_next = r_acc + w_partial;
    assign stall      = (w_idle & in_valid & w_is_mul & ~freeze & ~flush)
                      | ((r_state == StMul) & ~w_mul_last);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state   <= StIdle;
            r_cnt     <= '0;
            r_mul_a   <= '0;
            r_mul_b   <= '0;
            r_acc     <= '0;
            r_mul_cv  <= '0;
            r_mul_dst <= '0;
            r_mul_wb  <= 1'b0;
        end else if (flush) begin
            r_state <= StIdle;
        end else if (!freeze) begin
            case (r_state)
                StIdle: if (in_valid && w_is_mul) begin
                    r_state   <= StMul;
                    r_cnt     <= '0;
                    r_acc     <= '0;
                    r_mul_a   <= w_op_a;
                    r_mul_b   <= w_op_r;
                    r_mul_cv  <= SR[1:0];
                    r_mul_dst <= dst;
                    r_mul_wb  <= WB_en;
                end
                StMul: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    r_acc <= w_acc_next;
                    if (w_mul_last) r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end
`else
    assign w_idle   = 1'b1;
    assign w_is_mul = 1'b0;
    assign stall    = 1'b0;
`endif

    always_comb begin
        w_wr      = w_idle & in_valid & ~w_is_mul;
        w_wr_res  = w_alu_res;
        w_wr_sr   = {w_alu_res[MSB], ~|w_alu_res, w_c, w_v};
        w_wr_rm   = w_op_r;
        w_wr_br   = pc + w_br_off;
        w_wr_dst  = dst;
        w_wr_ctrl = {mem_R, mem_W, WB_en, B};
`ifdef EXE_MUL_EN
        if (r_state == StMul && w_mul_last) begin
            w_wr      = 1'b1;
            w_wr_res  = w_acc_next;
            w_wr_sr   = {w_acc_next[MSB], ~|w_acc_next, r_mul_cv};
            w_wr_rm   = r_mul_b;
            w_wr_br   = r_branch;
            w_wr_dst  = r_mul_dst;
            w_wr_ctrl = {2'b00, r_mul_wb, 1'b0};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_out_valid <= 1'b0;
            r_alu_res   <= '0;
            r_val_rm    <= '0;
            r_branch    <= '0;
            r_sr        <= '0;
            r_dst       <= '0;
            {r_mem_r, r_mem_w, r_wb_en, r_b} <= '0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (!freeze) begin
            r_out_valid <= w_wr;
            if (w_wr) begin
                r_alu_res <= w_wr_res;
                r_val_rm  <= w_wr_rm;
                r_branch  <= w_wr_br;
                r_sr      <= w_wr_sr;
                r_dst     <= w_wr_dst;
                {r_mem_r, r_mem_w, r_wb_en, r_b} <= w_wr_ctrl;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign ALU_res     = r_alu_res;
    assign val_Rm_out  = r_val_rm;
    assign branch_addr = r_branch;
    assign SR_out      = r_sr;
    assign dst_out     = r_dst;
    assign mem_R_out   = r_mem_r;
    assign mem_W_out   = r_mem_w;
    assign WB_en_out   = r_wb_en;
    assign B_out       = r_b;
endmodule

// File: tb/tb_exe_stage_pipelined.sv
// Randomized bench for exe_stage_pipelined against an arithmetic reference model.
// MUL scenarios are exercised when EXE_MUL_EN is defined; otherwise opcode 1010 is checked as MOV.
module tb_exe_stage_pipelined;
    localparam int DW = 32, MC = 4, BRS = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, freeze, flush, in_valid;
    logic [31:0] pc, val_Rn, val_Rm, val_MEM_stage, val_WB_stage;
    logic [1:0]  src1_sel, src2_sel;
    logic [3:0]  EX_command, SR, dst;
    logic        mem_R, mem_W, imm, WB_en, B;
    logic [11:0] shifter_operand;
    logic [23:0] signed_immediate;
    logic        stall, out_valid, mem_R_out, mem_W_out, WB_en_out, B_out;
    logic [31:0] ALU_res, val_Rm_out, branch_addr;
    logic [3:0]  SR_out, dst_out;

    int n_vec = 0, n_bad = 0;
    logic        e_valid;
    logic [31:0] e_res, e_rm, e_br;
    logic [3:0]  e_sr, e_dst, e_ctrl;

    exe_stage_pipelined #(.DATA_W(DW), .MUL_CYCLES(MC), .BR_SHIFT(BRS)) dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush), .in_valid(in_valid),
        .pc(pc), .val_Rn(val_Rn), .val_Rm(val_Rm), .val_MEM_stage(val_MEM_stage),
        .val_WB_stage(val_WB_stage), .src1_sel(src1_sel), .src2_sel(src2_sel),
        .EX_command(EX_command), .SR(SR), .dst(dst), .mem_R(mem_R), .mem_W(mem_W),
        .imm(imm), .WB_en(WB_en), .B(B), .shifter_operand(shifter_operand),
        .signed_immediate(signed_immediate), .stall(stall), .out_valid(out_valid),
        .ALU_res(ALU_res), .val_Rm_out(val_Rm_out), .branch_addr(branch_addr),
        .SR_out(SR_out), .dst_out(dst_out), .mem_R_out(mem_R_out), .mem_W_out(mem_W_out),
        .WB_en_out(WB_en_out), .B_out(B_out)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] fwd_ref(input logic [1:0] sel, input logic [31:0] v);
        if (sel == 2'b01) return val_MEM_stage;
        if (sel == 2'b10) return val_WB_stage;
        return v;
    endfunction

    function automatic logic [31:0] rot_ref(input longint unsigned x, input int n);
        longint unsigned y;
        y = (x >> n) | (x << (32 - n));
        return y[31:0];
    endfunction

    function automatic logic [31:0] val2_ref(input logic [31:0] r, input logic [11:0] so,
                                             input logic memrw, input logic im);
        longint unsigned x;
        int              s;
        int              n;
        if (memrw) return {20'd0, so};
        if (im) return rot_ref({56'd0, so[7:0]}, 2 * int'(so[11:8]));
        n = int'(so[11:7]);
        x = {32'd0, r};
        s = $signed(r);
        case (so[6:5])
            2'b00:   begin x = x << n; return x[31:0]; end
            2'b01:   return r >> n;
            2'b10:   begin s = s >>> n; return s; end
            default: return rot_ref(x, n);
        endcase
    endfunction

    task automatic alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sr, output logic [31:0] res, output logic [3:0] fl);
        longint unsigned ua, ub, full, bw;
        longint          sa, sb, ss;
        logic            c, v;
        ua = {32'd0, a}; ub = {32'd0, b};
        sa = $signed(a); sb = $signed(b);
        c = sr[1]; v = sr[0]; full = 0; ss = 0; bw = {63'd0, ~sr[1]};
        case (op)
            4'b0001, 4'b1010: res = b;
            4'b1001: res = ~b;
            4'b0110: res = a & b;
            4'b0111: res = a | b;
            4'b1000: res = a ^ b;
            4'b0010: begin full = ua + ub; ss = sa + sb; end
            4'b0011: begin full = ua + ub + {63'd0, sr[1]}; ss = sa + sb + longint'(sr[1]); end
            4'b0100: begin full = ua - ub; ss = sa - sb; end
            4'b0101: begin full = ua - ub - bw; ss = sa - sb - longint'(bw); end
            default: res = 0;
        endcase
        if (op inside {4'b0010, 4'b0011, 4'b0100, 4'b0101}) begin
            res = full[31:0];
            if (op inside {4'b0010, 4'b0011}) c = full[32];
            else c = (op == 4'b0100) ? (ua >= ub) : (ua >= ub + bw);
            v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end
        fl = {res[31], res == 0, c, v};
    endtask

    task automatic clear_in();
        freeze = 0; flush = 0; in_valid = 0; pc = 0; val_Rn = 0; val_Rm = 0;
        val_MEM_stage = 0; val_WB_stage = 0; src1_sel = 0; src2_sel = 0; EX_command = 4'b0001;
        SR = 0; dst = 0; mem_R = 0; mem_W = 0; imm = 0; WB_en = 0; B = 0;
        shifter_operand = 0; signed_immediate = 0;
    endtask

    task automatic check_outs();
        check_eq("out_valid", out_valid, e_valid);
        check_eq("alu_res", ALU_res, e_res);
        check_eq("sr_out", SR_out, e_sr);
        check_eq("val_rm_out", val_Rm_out, e_rm);
        check_eq("branch_addr", branch_addr, e_br);
        check_eq("dst_out", dst_out, e_dst);
        check_eq("ctrl_out", {mem_R_out, mem_W_out, WB_en_out, B_out}, e_ctrl);
    endtask

    // One cycle of a non-MUL instruction stream: predict, clock, compare
    task automatic tick();
        logic [31:0] a, r, v2, res, br, off;
        logic [3:0]  fl;
        #1;
        if (rst) check_eq("stall_idle", stall, 0);
        a   = fwd_ref(src1_sel, val_Rn);
        r   = fwd_ref(src2_sel, val_Rm);
        v2  = val2_ref(r, shifter_operand, mem_R | mem_W, imm);
        alu_ref(EX_command, a, v2, SR, res, fl);
        off = {{8{signed_immediate[23]}}, signed_immediate};
        br  = pc + (off << BRS);
        @(posedge clk); #1;
        if (!rst) begin
            e_valid = 0; e_res = 0; e_rm = 0; e_br = 0; e_sr = 0; e_dst = 0; e_ctrl = 0;
        end else if (flush) begin
            e_valid = 0;
        end else if (!freeze) begin
            e_valid = in_valid;
            if (in_valid) begin
                e_res = res; e_sr = fl; e_rm = r; e_br = br; e_dst = dst;
                e_ctrl = {mem_R, mem_W, WB_en, B};
            end
        end
        check_outs();
    endtask

    function automatic logic [3:0] rnd_op();
        case ($urandom_range(0, 9))
            0: return 4'b0001;
            1: return 4'b1001;
            2: return 4'b0010;
            3: return 4'b0011;
            4: return 4'b0100;
            5: return 4'b0101;
            6: return 4'b0110;
            7: return 4'b0111;
            8: return 4'b1000;
`ifdef EXE_MUL_EN
            default: return 4'b0010;
`else
            default: return 4'b1010;
`endif
        endcase
    endfunction

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFFFFFF;
            2: return 32'h80000000;
            3: return 32'h7FFFFFFF;
            default: return $urandom;
        endcase
    endfunction

`ifdef EXE_MUL_EN
    task automatic run_mul(input logic [31:0] a, input logic [31:0] r, input int frz_at,
                           input int frz_len, input int flush_at);
        int              p;
        bit              done;
        longint unsigned prod;
        logic [31:0]     res;
        logic [3:0]      srv, d;
        clear_in();
        srv = 4'($urandom); d = 4'($urandom);
        prod = {32'd0, a} * {32'd0, r};
        res = prod[31:0];
        in_valid = 1; EX_command = 4'b1010; val_Rn = a; val_WB_stage = r; src2_sel = 2'b10;
        val_Rm = $urandom; SR = srv; dst = d; WB_en = 1;
        p = 0; done = 0;
        for (int cyc = 0; cyc < MC + frz_len + 3 && !done; cyc++) begin
            freeze = (cyc >= frz_at && cyc < frz_at + frz_len);
            flush  = (cyc == flush_at);
            #1;
            check_eq("mul_stall", stall, (p == 0) ? 32'(!freeze && !flush) : 32'(p < MC));
            @(posedge clk); #1;
            if (flush) begin
                check_eq("flush_valid", out_valid, 0);
                e_valid = 0;
                flush = 0; in_valid = 0;
                #1;
                check_eq("flush_stall", stall, 0);
                done = 1;
            end else begin
                if (!freeze) p++;
                if (p == MC + 1) begin
                    e_valid = 1; e_res = res; e_sr = {res[31], res == 0, srv[1:0]};
                    e_rm = r; e_dst = d; e_ctrl = 4'b0010;
                    check_eq("mul_valid", out_valid, 1);
                    check_eq("mul_res", ALU_res, e_res);
                    check_eq("mul_sr", SR_out, e_sr);
                    check_eq("mul_rm", val_Rm_out, e_rm);
                    check_eq("mul_dst", dst_out, e_dst);
                    check_eq("mul_ctrl", {mem_R_out, mem_W_out, WB_en_out, B_out}, e_ctrl);
                    done = 1;
                end else begin
                    check_eq("mul_bubble", out_valid, 0);
                end
                if (p == 1) begin
                    val_WB_stage = $urandom; val_Rn = $urandom; val_MEM_stage = $urandom;
                end
            end
        end
        clear_in();
    endtask
`endif

    initial begin
        clear_in();
        e_valid = 0; e_res = 0; e_rm = 0; e_br = 0; e_sr = 0; e_dst = 0; e_ctrl = 0;
        rst = 0; in_valid = 1; EX_command = 4'b0010; val_Rn = 32'h1234; dst = 4'd3; WB_en = 1;
        tick();
        tick();
        rst = 1;

        clear_in();
        in_valid = 1; EX_command = 4'b0010; val_Rn = 5; val_MEM_stage = 32'h7FFFFFFF;
        src1_sel = 2'b01; imm = 1; shifter_operand = 12'h001; dst = 4'd7; WB_en = 1;
        tick();
        check_eq("add_fwd_res", ALU_res, 32'h80000000);
        check_eq("add_fwd_sr", SR_out, 4'b1001);

        clear_in();
        in_valid = 1; val_Rm = 32'hF0000000; shifter_operand = 12'h240;
        tick();
        check_eq("asr4", ALU_res, 32'hFF000000);

        clear_in();
        in_valid = 1; imm = 1; shifter_operand = 12'h2FF;
        tick();
        check_eq("imm_rot", ALU_res, 32'hF000000F);

        clear_in();
        in_valid = 1; B = 1; pc = 32'h100; signed_immediate = 24'hFFFFF0;
        tick();
        check_eq("branch", branch_addr, 32'h000000C0);

`ifdef EXE_MUL_EN
        run_mul(32'd7, 32'hFFFFFFFF, 99, 0, 99);
        check_eq("mul_const", ALU_res, 32'hFFFFFFF9);
        tick();
        run_mul(32'd7, 32'hFFFFFFFF, 2, 2, 99);
        run_mul($urandom, $urandom, 99, 0, 1);
        clear_in();
        in_valid = 1; EX_command = 4'b0010; val_Rn = 32'd40; imm = 1; shifter_operand = 12'h002;
        tick();
        check_eq("add_after_flush", ALU_res, 32'd42);
        for (int i = 0; i < 6; i++) begin
            run_mul(rnd_val(), rnd_val(), (i % 2 == 0) ? 99 : 1 + i % 3, 1 + i % 2, 99);
            tick();
        end
`else
        clear_in();
        in_valid = 1; EX_command = 4'b1010; imm = 1; shifter_operand = 12'h0AB; SR = 4'b0011;
        tick();
        check_eq("op1010_mov", ALU_res, 32'h000000AB);
        check_eq("op1010_sr", SR_out, 4'b0011);
        check_eq("op1010_stall", stall, 0);
`endif

        for (int i = 0; i < 300; i++) begin
            in_valid = ($urandom_range(0, 9) < 8);
            freeze = ($urandom_range(0, 9) == 0);
            flush = ($urandom_range(0, 11) == 0);
            pc = $urandom; val_Rn = rnd_val(); val_Rm = rnd_val();
            val_MEM_stage = rnd_val(); val_WB_stage = rnd_val();
            src1_sel = 2'($urandom); src2_sel = 2'($urandom);
            EX_command = rnd_op(); SR = 4'($urandom); dst = 4'($urandom);
            mem_R = ($urandom_range(0, 7) == 0); mem_W = ($urandom_range(0, 7) == 0);
            imm = 1'($urandom); WB_en = 1'($urandom); B = 1'($urandom);
            shifter_operand = 12'($urandom); signed_immediate = 24'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
